// File: rtl/unified_mem_arbiter.sv
// Unified instruction/data memory arbiter: shares one single-ported memory
// between the IF stage (fetch) and the MEM stage (load/store).
// Optional watchdog: define MEM_TIMEOUT_EN to abort transactions that never
// see mem_ready_i; otherwise the block waits indefinitely and mem_err_o is 0.
module unified_mem_arbiter #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned STARVE_LIMIT   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_valid_o,
   input  logic              dm_read_i,
   input  logic              dm_write_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              dm_valid_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ready_i,
   output logic              stall_if_o,
   output logic              stall_mem_o,
   output logic              mem_err_o
);

   localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DATA  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
   logic                if_valid_q, if_valid_d;
   logic                dm_valid_q, dm_valid_d;
   logic                dm_req;
   logic                starve_ok;

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned WDOG_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [WDOG_W-1:0]   wdog_q, wdog_d;
   logic                mem_err_q, mem_err_d;
`endif

   // A simultaneous read and write is treated as a write (mem_we follows dm_write_i).
   assign dm_req    = dm_read_i | dm_write_i;
   assign starve_ok = (starve_q < STARVE_W'(STARVE_LIMIT));

   // Arbitration, grant capture, completion and (optionally) watchdog abort.
   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      if_valid_d  = 1'b0;
      dm_valid_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
      wdog_d      = wdog_q;
      mem_err_d   = 1'b0;
`endif

      // No pending fetch means nothing is being starved.
      if (!if_req_i) begin
         starve_d = '0;
      end

      unique case (state_q)
         IDLE: begin
            if (dm_req && (starve_ok || !if_req_i)) begin
               state_d     = DATA;
               mem_req_d   = 1'b1;
               mem_we_d    = dm_write_i;
               mem_addr_d  = dm_addr_i;
               mem_wdata_d = dm_wdata_i;
               if (if_req_i && starve_ok) begin
                  starve_d = starve_q + STARVE_W'(1);
               end
`ifdef MEM_TIMEOUT_EN
               wdog_d      = '0;
`endif
            end else if (if_req_i) begin
               state_d    = FETCH;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = if_addr_i;
               starve_d   = '0;
`ifdef MEM_TIMEOUT_EN
               wdog_d     = '0;
`endif
            end
         end
         FETCH, DATA: begin
            if (mem_ready_i) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               if (state_q == FETCH) begin
                  if_rdata_d = mem_rdata_i;
                  if_valid_d = 1'b1;
               end else begin
                  if (!mem_we_q) begin
                     dm_rdata_d = mem_rdata_i;
                  end
                  dm_valid_d = 1'b1;
               end
`ifdef MEM_TIMEOUT_EN
            end else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               mem_err_d = 1'b1;
               if (state_q == FETCH) begin
                  if_rdata_d = '0;
                  if_valid_d = 1'b1;
               end else begin
                  if (!mem_we_q) begin
                     dm_rdata_d = '0;
                  end
                  dm_valid_d = 1'b1;
               end
            end else begin
               wdog_d = wdog_q + WDOG_W'(1);
`endif
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs; synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_valid_q  <= 1'b0;
         dm_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_valid_q  <= if_valid_d;
         dm_valid_q  <= dm_valid_d;
      end
   end

`ifdef MEM_TIMEOUT_EN
   // Watchdog counter and error pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wdog_q    <= '0;
         mem_err_q <= 1'b0;
      end else begin
         wdog_q    <= wdog_d;
         mem_err_q <= mem_err_d;
      end
   end

   assign mem_err_o = mem_err_q;
`else
   assign mem_err_o = 1'b0;
`endif

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign if_rdata_o  = if_rdata_q;
   assign dm_rdata_o  = dm_rdata_q;
   assign if_valid_o  = if_valid_q;
   assign dm_valid_o  = dm_valid_q;

   // Pipeline freezes while a requester is waiting for its completion pulse.
   assign stall_if_o  = if_req_i & ~if_valid_q;
   assign stall_mem_o = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter.
module tb_unified_mem_arbiter;

   localparam int unsigned TB_TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        dm_read;
   logic        dm_write;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_valid;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        stall_if;
   logic        stall_mem;
   logic        mem_err;

   int tests_run = 0;
   int tests_failed = 0;

   unified_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(TB_TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_valid_o(if_valid),
      .dm_read_i(dm_read), .dm_write_i(dm_write), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
      .dm_rdata_o(dm_rdata), .dm_valid_o(dm_valid),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
      .stall_if_o(stall_if), .stall_mem_o(stall_mem), .mem_err_o(mem_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Memory answers with mem_ready after lat further cycles; returns in the valid cycle.
   task automatic serve(input int lat, input logic [31:0] data);
      repeat (lat) step();
      mem_ready = 1'b1;
      mem_rdata = data;
      step();
      mem_ready = 1'b0;
      mem_rdata = '0;
   endtask

   task automatic wait_grant(input string tag);
      int n = 0;
      while (mem_req !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check_eq({tag, "_grant"}, 32'(mem_req), 32'd1);
   endtask

   initial begin
      logic exp_we [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      rst_n = 1'b0; if_req = 0; if_addr = '0; dm_read = 0; dm_write = 0;
      dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ready = 0;
      repeat (3) step();
      rst_n = 1'b1;
      step();

      // Reset state
      check_eq("rst_mem_req", 32'(mem_req), 32'd0);
      check_eq("rst_mem_addr", mem_addr, 32'h0);
      check_eq("rst_if_valid", 32'(if_valid), 32'd0);
      check_eq("rst_dm_valid", 32'(dm_valid), 32'd0);
      check_eq("rst_rdata", if_rdata | dm_rdata, 32'h0);
      check_eq("rst_mem_err", 32'(mem_err), 32'd0);

      // 1. Fetch only
      if_req = 1; if_addr = 32'h100;
      #1 check_eq("t1_stall_if_req", 32'(stall_if), 32'd1);
      step();
      check_eq("t1_mem_req", 32'(mem_req), 32'd1);
      check_eq("t1_mem_addr", mem_addr, 32'h100);
      check_eq("t1_mem_we", 32'(mem_we), 32'd0);
      serve(2, 32'h00A00093);
      check_eq("t1_if_valid", 32'(if_valid), 32'd1);
      check_eq("t1_if_rdata", if_rdata, 32'h00A00093);
      check_eq("t1_stall_if_done", 32'(stall_if), 32'd0);
      check_eq("t1_mem_req_drop", 32'(mem_req), 32'd0);
      if_req = 0;
      step();
      check_eq("t1_if_valid_pulse", 32'(if_valid), 32'd0);
      check_eq("t1_no_err", 32'(mem_err), 32'd0);

      // 2. Simultaneous fetch and load: data first
      if_req = 1; if_addr = 32'h104; dm_read = 1; dm_addr = 32'h200;
      step();
      check_eq("t2_data_addr", mem_addr, 32'h200);
      check_eq("t2_data_we", 32'(mem_we), 32'd0);
      check_eq("t2_stall_if", 32'(stall_if), 32'd1);
      check_eq("t2_stall_mem", 32'(stall_mem), 32'd1);
      serve(1, 32'h12345678);
      check_eq("t2_dm_valid", 32'(dm_valid), 32'd1);
      check_eq("t2_dm_rdata", dm_rdata, 32'h12345678);
      check_eq("t2_if_valid_low", 32'(if_valid), 32'd0);
      check_eq("t2_stall_if_hold", 32'(stall_if), 32'd1);
      dm_read = 0;
      step();
      check_eq("t2_fetch_req", 32'(mem_req), 32'd1);
      check_eq("t2_fetch_addr", mem_addr, 32'h104);
      check_eq("t2_dm_valid_pulse", 32'(dm_valid), 32'd0);
      serve(1, 32'h00000013);
      check_eq("t2_if_valid", 32'(if_valid), 32'd1);
      check_eq("t2_if_rdata", if_rdata, 32'h00000013);
      if_req = 0;
      step();

      // 3. Starvation: 4 data grants, 1 fetch, data again
      if_req = 1; if_addr = 32'h300; dm_write = 1; dm_addr = 32'h80; dm_wdata = 32'h11;
      for (int g = 0; g < 6; g++) begin
         wait_grant($sformatf("t3_g%0d", g));
         check_eq($sformatf("t3_we_g%0d", g), 32'(mem_we), 32'(exp_we[g]));
         check_eq($sformatf("t3_addr_g%0d", g), mem_addr, exp_we[g] ? 32'h80 : 32'h300);
         serve(0, 32'h0);
      end
      if_req = 0; dm_write = 0;
      step();

      // 4. Store with data changing during the wait
      dm_write = 1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
      step();
      check_eq("t4_mem_we", 32'(mem_we), 32'd1);
      check_eq("t4_mem_wdata", mem_wdata, 32'hDEADBEEF);
      dm_wdata = 32'hCAFEF00D; dm_addr = 32'h44;
      step();
      check_eq("t4_wdata_hold", mem_wdata, 32'hDEADBEEF);
      check_eq("t4_addr_hold", mem_addr, 32'h40);
      serve(1, 32'h55555555);
      check_eq("t4_dm_valid", 32'(dm_valid), 32'd1);
      check_eq("t4_dm_rdata_kept", dm_rdata, 32'h12345678);
      dm_write = 0;
      step();

      // 5. Reset while in DATA, late mem_ready ignored
      if_req = 1; if_addr = 32'h500; dm_read = 1; dm_addr = 32'h60;
      step();
      check_eq("t5_data_grant", mem_addr, 32'h60);
      step();
      rst_n = 0;
      step();
      rst_n = 1; if_req = 0; dm_read = 0;
      check_eq("t5_mem_req_drop", 32'(mem_req), 32'd0);
      check_eq("t5_no_dm_valid", 32'(dm_valid), 32'd0);
      mem_ready = 1; mem_rdata = 32'hBADBAD00;
      step();
      mem_ready = 0; mem_rdata = '0;
      check_eq("t5_late_ready_valid", 32'(if_valid | dm_valid), 32'd0);
      check_eq("t5_late_ready_rdata", dm_rdata, 32'h0);
      check_eq("t5_idle_no_req", 32'(mem_req), 32'd0);
      if_req = 1; if_addr = 32'h500;
      step();
      check_eq("t5_new_grant_addr", mem_addr, 32'h500);
      serve(0, 32'h0000ABCD);
      check_eq("t5_new_if_rdata", if_rdata, 32'h0000ABCD);
      if_req = 0;
      step();

`ifdef MEM_TIMEOUT_EN
      // 6. Watchdog abort
      if_req = 1; if_addr = 32'h600;
      step();
      check_eq("t6_grant", 32'(mem_req), 32'd1);
      for (int c = 1; c < int'(TB_TIMEOUT); c++) begin
         step();
         check_eq($sformatf("t6_wait_err_c%0d", c), 32'(mem_err), 32'd0);
      end
      step();
      check_eq("t6_mem_err", 32'(mem_err), 32'd1);
      check_eq("t6_if_valid", 32'(if_valid), 32'd1);
      check_eq("t6_if_rdata", if_rdata, 32'h0);
      check_eq("t6_mem_req_drop", 32'(mem_req), 32'd0);
      if_req = 0; dm_read = 1; dm_addr = 32'h700;
      step();
      check_eq("t6_err_pulse", 32'(mem_err), 32'd0);
      check_eq("t6_next_addr", mem_addr, 32'h700);
      serve(0, 32'h77);
      check_eq("t6_next_rdata", dm_rdata, 32'h77);
      dm_read = 0;
      step();
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the pipeline's IF stage (fetch) and MEM stage (load/store).
- Registered request/ready handshake toward memory, with variable latency.
- Returns read data and one-cycle valid pulses to each requester.
- Drives stall signals that freeze the pipeline while a requester waits.
- The MEM-stage request comes straight from the decoded MemRead/MemWrite control bits.

Parameters:
- ADDR_W, 32: address width, byte addressed.
- DATA_W, 32: data width.
- STARVE_LIMIT, 4: maximum consecutive data grants while a fetch is pending. The next grant is then forced to fetch.
- TIMEOUT_CYCLES, 255: watchdog limit, used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction; registered.
- if_valid  out  1  one-cycle pulse; fetch complete.
- dm_read  in  1  load request (MemRead).
- dm_write  in  1  store request (MemWrite).
- dm_addr  in  ADDR_W  load/store address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; registered.
- dm_valid  out  1  one-cycle pulse; load/store complete.
- mem_req  out  1  memory request; registered.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  memory address; registered.
- mem_wdata  out  DATA_W  memory write data; registered.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ready.
- mem_ready  in  1  memory completion, one cycle.
- stall_if  out  1  equals if_req & ~if_valid (combinational).
- stall_mem  out  1  equals (dm_read|dm_write) & ~dm_valid (combinational).
- mem_err  out  1  one-cycle pulse: transaction aborted by timeout.

Behaviour:
- Reset: clk and synchronous active-low rst_n (rst_n sampled on rising clk).
  - State goes to IDLE. The starve counter is cleared.
  - All registered outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_valid, dm_valid, mem_err.
- dm_read and dm_write both high is illegal: treat as a write.
- States: IDLE, FETCH, DATA.
- IDLE arbitration, evaluated each cycle:
  - dm request and (starve < STARVE_LIMIT or ~if_req): go to DATA.
  - Else if if_req: go to FETCH.
  - Else stay in IDLE.
- On a grant edge, capture into the mem_* registers: address, we, wdata (data grant), and mem_req = 1.
  - mem_req rises 1 cycle after the request is seen in IDLE.
- mem_addr, mem_we and mem_wdata stay stable while mem_req = 1. They do not track the requester's inputs.
- mem_ready while in FETCH or DATA (completion):
  - Next edge: mem_req = 0 and state = IDLE.
  - Capture mem_rdata into if_rdata, or into dm_rdata for a read. dm_rdata is unchanged on a write.
  - Pulse if_valid or dm_valid for exactly 1 cycle.
- Completion leaves one idle cycle. Minimum per-access occupancy is mem_ready latency + 2 cycles.
- mem_ready while in IDLE is ignored.
- Starve counter:
  - +1 on a data grant while if_req = 1, saturating at STARVE_LIMIT.
  - Cleared on a fetch grant, or on any cycle with if_req = 0.
- A requester that drops its request mid-transaction does not cancel it. The access completes, the valid pulse is still issued, and write side effects still occur.
- Valid pulses and stalls are independent per requester. Both stall signals may be high at once.
- Reset mid-transaction: mem_req drops on that edge with no valid pulse. The memory must tolerate the abandoned request.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - An 8+ bit watchdog counts cycles in FETCH/DATA with mem_req = 1.
  - On reaching TIMEOUT_CYCLES without mem_ready: mem_req drops, the granted requester's valid pulses with rdata = 0, mem_err pulses 1 cycle, and state returns to IDLE.
  - The watchdog clears on every grant.
- Undefined: no watchdog; mem_err is tied to 0; the block waits indefinitely for mem_ready.

Test Plan:
1. Fetch only:
   - Stimulus: if_req = 1, if_addr = 0x100; memory answers mem_ready 2 cycles after mem_req with 0x00A00093.
   - Required: mem_req rises 1 cycle after if_req; mem_addr = 0x100, mem_we = 0; if_valid pulses once with if_rdata = 0x00A00093; stall_if high until then.
2. Simultaneous requests:
   - Stimulus: if_req and dm_read, addr 0x200, both asserted in IDLE.
   - Required: data served first (mem_addr = 0x200, dm_valid pulse); fetch granted next; stall_if stays high throughout the data access.
3. Starvation:
   - Stimulus: dm_write held continuously and if_req held, STARVE_LIMIT = 4.
   - Required: exactly 4 data grants (mem_we = 1), then 1 fetch grant, then data again.
4. Store:
   - Stimulus: dm_write = 1, dm_addr = 0x40, dm_wdata = 0xDEADBEEF; change dm_wdata during wait.
   - Required: mem_wdata stays 0xDEADBEEF until mem_ready; dm_valid pulses; dm_rdata unchanged.
5. Reset during access:
   - Stimulus: rst_n = 0 for 1 cycle while in DATA.
   - Required: mem_req = 0 on that edge, no dm_valid, state IDLE, starve counter 0; a late mem_ready is ignored.
6. Timeout (MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES = 8):
   - Stimulus: never assert mem_ready.
   - Required: after 8 cycles, mem_err and if_valid pulse together, if_rdata = 0, arbiter accepts next request.
